// File: rtl/mc_controller_pkg.sv
// ctrl_pkg: shared state, opcode and datapath select encodings for the multi-cycle RV32I core
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Dispatch target out of DECODE; unknown opcodes land in TRAP
    function automatic state_t decode_state(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEMADR;
            OP_R:         return S_EXECR;
            OP_I_ALU:     return S_EXECI;
            OP_BEQ:       return S_BEQ;
            OP_JAL:       return S_JAL;
            OP_LUI:       return S_LUI;
            default:      return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// alu_decoder: maps the controller's ALU request and funct fields to an ALU operation
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op_5,
    output logic [2:0] alu_control
);

    logic [2:0] funct_ctl;

    // sub only for R-type (op[5]=1) with funct7[5]; I-ALU funct3 000 is always addi
    always_comb begin
        funct_ctl = ALU_ADD;
        case (funct3)
            3'b000:  funct_ctl = (funct7_5 && op_5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_ctl = ALU_SLT;
            3'b110:  funct_ctl = ALU_OR;
            3'b111:  funct_ctl = ALU_AND;
            default: funct_ctl = ALU_ADD;
        endcase
        alu_control = (alu_op == ALU_OP_SUB)   ? ALU_SUB :
                      (alu_op == ALU_OP_FUNCT) ? funct_ctl : ALU_ADD;
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle RV32I main FSM driving datapath selects and a variable-latency memory port
module mc_controller
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            alu_control,
    output logic [2:0]            imm_src,
    output logic                  illegal
);

    state_t     state_q, state_d;
    logic [6:0] op;
    logic [1:0] alu_op;
    logic [2:0] alu_dec;
    logic       unused_instr;

    assign op           = instr[6:0];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (instr[14:12]),
        .funct7_5    (instr[30]),
        .op_5        (instr[5]),
        .alu_control (alu_dec)
    );

    // reset forces every output low, including the ALU op selected by the decoder
    assign alu_control = rst ? ALU_ADD : alu_dec;

    // state register; async reset parks the FSM in FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // next state and per-state datapath controls, all gated off while rst is high
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        alu_op     = ALU_OP_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                state_d    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
                state_d   = decode_state(op);
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
                state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALU_OP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                alu_op    = ALU_OP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALU_OP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = RES_ALUOUT;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_RS2;
            imm_src    = IMM_I;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized instruction stream checked cycle by cycle against a per-instruction phase plan
module tb_mc_controller;

    logic        clk, rst, zero, mem_ready;
    logic [31:0] instr;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [2:0]  alu_control, imm_src;
    int          checks = 0;
    int          errors = 0;

    // irw/pcw codes: 0 low, 1 high, 2 follows mem_ready, 3 follows zero
    typedef struct packed {
        logic       req, wr, adr, rw, ill, mem;
        logic [1:0] irw, pcw, res, a, b;
        logic [2:0] alu, imm;
    } step_t;

    step_t plan_q[$];

    mc_controller #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .imm_src(imm_src), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] got_v();
        return {13'd0, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal};
    endfunction

    function automatic logic dyn(input logic [1:0] c);
        return (c == 2'd0) ? 1'b0 : (c == 2'd1) ? 1'b1 : (c == 2'd2) ? mem_ready : zero;
    endfunction

    function automatic logic [31:0] exp_v(input step_t s);
        return {13'd0, s.req, s.wr, s.adr, dyn(s.irw), dyn(s.pcw), s.rw,
                s.res, s.a, s.b, s.alu, s.imm, s.ill};
    endfunction

    // ALU operation an instruction's funct fields ask for
    function automatic logic [2:0] alu_ref(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        if (f3 == 3'd0) return (ins[6:0] == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
        if (f3 == 3'd2) return 3'd5;
        if (f3 == 3'd6) return 3'd3;
        if (f3 == 3'd7) return 3'd2;
        return 3'd0;
    endfunction

    // phase list an instruction goes through, with the controls each phase must show
    function automatic void build(input logic [31:0] ins);
        step_t s, wb;
        logic [6:0] op;
        op = ins[6:0];
        plan_q.delete();
        s = '0; s.req = 1; s.irw = 2; s.pcw = 2; s.b = 2; s.res = 2; s.mem = 1;
        plan_q.push_back(s);
        s = '0; s.a = 1; s.b = 1; s.imm = (op == 7'h6F) ? 3'd4 : 3'd2;
        plan_q.push_back(s);
        wb = '0; wb.rw = 1;
        case (op)
            7'h03, 7'h23: begin
                s = '0; s.a = 2; s.b = 1; s.imm = (op == 7'h23) ? 3'd1 : 3'd0;
                plan_q.push_back(s);
                s = '0; s.req = 1; s.adr = 1; s.mem = 1; s.wr = (op == 7'h23);
                plan_q.push_back(s);
                if (op == 7'h03) begin
                    s = '0; s.res = 1; s.rw = 1;
                    plan_q.push_back(s);
                end
            end
            7'h33: begin
                s = '0; s.a = 2; s.b = 0; s.alu = alu_ref(ins);
                plan_q.push_back(s); plan_q.push_back(wb);
            end
            7'h13: begin
                s = '0; s.a = 2; s.b = 1; s.alu = alu_ref(ins);
                plan_q.push_back(s); plan_q.push_back(wb);
            end
            7'h63: begin
                s = '0; s.a = 2; s.alu = 1; s.pcw = 3;
                plan_q.push_back(s);
            end
            7'h6F: begin
                s = '0; s.a = 1; s.b = 2; s.pcw = 1;
                plan_q.push_back(s); plan_q.push_back(wb);
            end
            7'h37: begin
                s = '0; s.a = 3; s.b = 1; s.imm = 3;
                plan_q.push_back(s); plan_q.push_back(wb);
            end
            default: begin
                s = '0; s.ill = 1;
                for (int i = 0; i < 20; i++) plan_q.push_back(s);
            end
        endcase
    endfunction

    // w: memory wait cycles (<0 random), z: zero flag (<0 random), abort: reset during the store wait
    task automatic run_instr(input logic [31:0] ins, input int w, input int z, input bit abort);
        build(ins);
        instr = ins;
        foreach (plan_q[k]) begin
            int waits;
            waits = !plan_q[k].mem ? 0 : (w < 0 ? int'($urandom_range(0, 2)) : w);
            for (int c = 0; c <= waits; c++) begin
                mem_ready = plan_q[k].mem ? (c == waits) : 1'($urandom_range(0, 1));
                zero = (z < 0) ? 1'($urandom_range(0, 1)) : z[0];
                if (abort && plan_q[k].wr) mem_ready = 1'b0;
                @(negedge clk);
                check($sformatf("%h/p%0d", ins, k), got_v(), exp_v(plan_q[k]));
                if (abort && plan_q[k].wr && c == 1) begin
                    #2 rst = 1'b1;
                    #1 check("rst_mid_store", got_v(), 32'd0);
                    @(posedge clk);
                    #1 rst = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        logic [6:0] ops [7];
        logic [31:0] ins;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h37};
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; instr = 32'h0;
        @(negedge clk);
        check("reset", got_v(), 32'd0);
        mem_ready = 1'b1; zero = 1'b1;
        @(negedge clk);
        check("reset_ready", got_v(), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(32'h002081B3, 0, -1, 0);
        run_instr(32'h0080A283, 3, -1, 0);
        run_instr(32'h00208863, 0, 1, 0);
        run_instr(32'h00208863, 0, 0, 0);
        run_instr(32'h001000EF, 0, -1, 0);
        run_instr(32'h123450B7, 0, -1, 0);
        run_instr(32'h0050A423, 2, -1, 0);
        run_instr(32'h40208133, 0, -1, 0);
        run_instr(32'h4050A093, 1, -1, 0);
        for (int n = 0; n < 150; n++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 6)];
            run_instr(ins, -1, -1, 0);
        end
        run_instr(32'h0000007F, 0, -1, 0);
        rst = 1'b1;
        #1 check("trap_rst", got_v(), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(32'h002081B3, 0, -1, 0);
        run_instr(32'h0050A423, 3, -1, 1);
        run_instr(32'h002081B3, 1, -1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle main controller for the RV32I core. It sequences one shared ALU, a unified instruction/data memory port and the immediate extender across fetch, decode, execute, memory and writeback states. It decodes the latched instruction word and drives every mux select and write enable in the datapath. It also handshakes with a variable-latency memory.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width; only 32 is supported.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  DATA_WIDTH  latched instruction register contents.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completed the current request this cycle.
- mem_req  output  1  memory access request.
- mem_write  output  1  the request is a store.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  output  1  load the instruction register and OldPC.
- pc_write  output  1  load the PC from the result bus.
- reg_write  output  1  register file write enable.
- result_src  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU result.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- alu_src_b  output  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- alu_control  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- imm_src  output  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J.
- illegal  output  1  sticky unsupported-opcode flag.

## Operation
- Supported opcodes: lw (0000011), sw (0100011), R-type (0110011), I-ALU (0010011), beq (1100011), jal (1101111), lui (0110111). Any other opcode is illegal.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, LUI, TRAP.
- FETCH: mem_req=1, adr_src=0, A=PC, B=4, add, result_src=10. ir_write and pc_write equal mem_ready. The controller stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: A=OldPC, B=imm, add. imm_src is J for jal, otherwise B. Next state is chosen by opcode: lw/sw→MEMADR, R→EXECR, I-ALU→EXECI, beq→BEQ, jal→JAL, lui→LUI, other→TRAP.
- MEMADR: A=rs1, B=imm, add, imm_src I (lw) or S (sw). Next state is MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req=1, adr_src=1. The controller waits for mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. The controller waits for mem_ready, then goes to FETCH.
- EXECR: A=rs1, B=rs2, R-type ALU decode, then ALUWB.
- EXECI: A=rs1, B=imm, imm_src I, I-type ALU decode, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ: A=rs1, B=rs2, sub, result_src=00, pc_write=zero, then FETCH.
- JAL: A=OldPC, B=4, add, result_src=00, pc_write=1, then ALUWB.
- LUI: A=zero, B=imm, imm_src U, add, then ALUWB.
- TRAP: illegal=1 and all enables are 0. TRAP is absorbing until rst.
- ALU decode:
  - funct3 000 is sub only when funct7[5]=1 and the instruction is R-type; otherwise add.
  - funct3 010 → slt, 110 → or, 111 → and.
  - Any other funct3 selects add.
- Any output not listed for a state is 0.

## Timing
- All outputs are combinational from the state register and instr; no registered outputs.
- While rst is high, the state is FETCH and all enables (mem_req, mem_write, ir_write, pc_write, reg_write, illegal) are forced to 0. All selects are 0.
- In the first cycle after rst is released, the controller issues the FETCH request.
- Memory handshake:
  - mem_req, mem_write and adr_src are held stable until a cycle where mem_ready=1. That cycle completes the transfer.
  - mem_ready while mem_req=0 is ignored.
  - Zero wait states is legal: mem_ready may be high in the first request cycle.
- Latency with zero-wait memory:
  - R, I-ALU, lui: 4 cycles.
  - sw, beq: 4 and 3 cycles.
  - lw: 5 cycles.
  - jal: 4 cycles.
  - Each memory wait cycle adds one cycle.
- Reset asserted mid-access (e.g. in MEMWRITE) drops mem_req and mem_write asynchronously in the same cycle; no partial write enable may persist.
- instr is only updated through ir_write, so decode is stable from DECODE onward.

## Structure
- Package ctrl_pkg contains:
  - the state enum;
  - opcode constants;
  - the imm_src, alu_control, result_src, alu_src_a and alu_src_b encodings.
- The immediate extender and datapath import the same encodings.
- Sub-module alu_decoder: combinational. Inputs are alu_op[1:0] (00 add, 01 sub, 10 funct-decoded), funct3, funct7[5] and opcode[5]. Output is alu_control.

## Test plan
- Reset then add x3,x1,x2 (0x002081B3), mem_ready tied to 1: states FETCH, DECODE, EXECR, ALUWB. reg_write=1 in cycle 4 with alu_control 000 in EXECR. pc_write=1 only in cycle 1.
- lw x5,8(x1) (0x0080A283) with mem_ready low for 3 cycles in MEMREAD: mem_req=1 and adr_src=1 are held stable for 4 cycles. MEMWB has result_src=01 and reg_write=1.
- beq x1,x2,+16 (0x00208863): with zero=1, pc_write=1 in BEQ; with zero=0, pc_write=0. imm_src=010 in DECODE.
- jal x1,+2048: DECODE imm_src=100; JAL pc_write=1; ALUWB reg_write=1 with result_src=00.
- Opcode 0x7F: TRAP, illegal=1 stays high over 20 cycles with all enables 0. rst clears it and returns to FETCH.
- sw with rst asserted mid-MEMWRITE: mem_req and mem_write fall in the same cycle as rst. After release, the state is FETCH.
